// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises async reset requests, enforces a hold time,
// then releases rst_out bits one by one in ascending order with a fixed gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ASSERT  | all rst_out high, accumulating request causes
// HOLD    | requests gone, counting HOLD_CYCLES clean cycles
// RELEASE | releasing rst_out[idx] every GAP_CYCLES
// RUN     | all rst_out released, ready high
module reset_sequencer #(
    parameter int N_REQ       = 2,
    parameter int N_OUT       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] rst_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready,
    output logic [N_REQ-1:0] rst_cause
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam int IW      = $clog2(N_OUT) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

    logic [SYNC_STAGES-1:0][N_REQ-1:0] sync;
    logic [SYNC_STAGES-1:0]            sync_valid;
    logic [N_REQ-1:0]                  req_bits;
    logic [N_REQ-1:0]                  cause_bits;
    logic                              req_s;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;

    // Stages preset to 1 keep ASSERT held until real samples arrive; sync_valid
    // marks which stages hold a real sample so the preset never counts as a cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= '1;
            sync_valid <= '0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], rst_req};
            sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign req_bits   = sync[SYNC_STAGES-1];
    assign req_s      = |req_bits;
    assign cause_bits = sync_valid[SYNC_STAGES-1] ? req_bits : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            rst_cause <= '0;
        end else if (req_s && state != ASSERT) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            rst_cause <= cause_bits;
        end else begin
            case (state)
                ASSERT: begin
                    rst_out   <= '1;
                    ready     <= 1'b0;
                    rst_cause <= rst_cause | cause_bits;
                    if (!req_s) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        idx     <= IW'(1);
                        if (N_OUT == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    // rst_out is a thermometer code, so shifting clears exactly bit idx
                    if (cnt == GAP_LAST) begin
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        idx     <= idx + IW'(1);
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    rst_out <= '0;
                    ready   <= 1'b1;
                end
                default: state <= ASSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: timeline vector table on the default
// instance, then a mid-sequence reset with release-edge checks on three configs.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] rst_req;

    logic [2:0] out_a;
    logic       rdy_a;
    logic [1:0] cause_a;
    logic [0:0] out_b;
    logic       rdy_b;
    logic [1:0] cause_b;
    logic [3:0] out_c;
    logic       rdy_c;
    logic [1:0] cause_c;

    int e;
    int errors;
    int checks;

    reset_sequencer #(.N_REQ(2), .N_OUT(3), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .rst_req(rst_req),
        .rst_out(out_a), .ready(rdy_a), .rst_cause(cause_a));

    reset_sequencer #(.N_REQ(2), .N_OUT(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_b (
        .clk(clk), .reset(reset), .rst_req(rst_req),
        .rst_out(out_b), .ready(rdy_b), .rst_cause(cause_b));

    reset_sequencer #(.N_REQ(2), .N_OUT(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(7)) u_c (
        .clk(clk), .reset(reset), .rst_req(rst_req),
        .rst_out(out_c), .ready(rdy_c), .rst_cause(cause_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [1:0] req;
        logic [2:0] out;
        logic       rdy;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[25];

    task automatic tick();
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    // Released-bit count from the release-edge formula, relative to E0.
    function automatic int released(int edge_no, int sync, int hold, int gap, int nout);
        int first;
        int k;
        first = sync + 1 + hold;
        if (edge_no < first) k = 0;
        else k = (edge_no - first) / gap + 1;
        if (k > nout) k = nout;
        return k;
    endfunction

    function automatic logic [31:0] out_for(int k, int nout);
        return ((32'd1 << nout) - 32'd1) & ~((32'd1 << k) - 32'd1);
    endfunction

    initial begin
        int k;
        errors = 0;
        checks = 0;
        e      = 0;

        // edge, req driven after the check, rst_out, ready, rst_cause
        vecs[0]  = '{1,  2'b00, 3'b111, 1'b0, 2'b00};
        vecs[1]  = '{3,  2'b00, 3'b111, 1'b0, 2'b00};
        vecs[2]  = '{18, 2'b00, 3'b111, 1'b0, 2'b00};
        vecs[3]  = '{19, 2'b00, 3'b110, 1'b0, 2'b00};
        vecs[4]  = '{22, 2'b00, 3'b110, 1'b0, 2'b00};
        vecs[5]  = '{23, 2'b00, 3'b100, 1'b0, 2'b00};
        vecs[6]  = '{26, 2'b00, 3'b100, 1'b0, 2'b00};
        vecs[7]  = '{27, 2'b00, 3'b000, 1'b1, 2'b00};
        vecs[8]  = '{30, 2'b10, 3'b000, 1'b1, 2'b00};
        vecs[9]  = '{32, 2'b10, 3'b000, 1'b1, 2'b00};
        vecs[10] = '{33, 2'b00, 3'b111, 1'b0, 2'b10};
        vecs[11] = '{34, 2'b00, 3'b111, 1'b0, 2'b10};
        vecs[12] = '{51, 2'b00, 3'b111, 1'b0, 2'b10};
        vecs[13] = '{52, 2'b00, 3'b110, 1'b0, 2'b10};
        vecs[14] = '{53, 2'b01, 3'b110, 1'b0, 2'b10};
        vecs[15] = '{55, 2'b01, 3'b110, 1'b0, 2'b10};
        vecs[16] = '{56, 2'b01, 3'b111, 1'b0, 2'b01};
        vecs[17] = '{58, 2'b11, 3'b111, 1'b0, 2'b01};
        vecs[18] = '{61, 2'b11, 3'b111, 1'b0, 2'b11};
        vecs[19] = '{62, 2'b10, 3'b111, 1'b0, 2'b11};
        vecs[20] = '{66, 2'b00, 3'b111, 1'b0, 2'b11};
        vecs[21] = '{68, 2'b00, 3'b111, 1'b0, 2'b11};
        vecs[22] = '{84, 2'b00, 3'b111, 1'b0, 2'b11};
        vecs[23] = '{85, 2'b00, 3'b110, 1'b0, 2'b11};
        vecs[24] = '{89, 2'b00, 3'b100, 1'b0, 2'b11};

        reset   = 1'b1;
        rst_req = 2'b00;
        tick();
        check("reset_out",   32'(out_a),   32'h7);
        check("reset_ready", 32'(rdy_a),   32'h0);
        check("reset_cause", 32'(cause_a), 32'h0);
        tick();
        reset = 1'b0;
        e     = 0;

        foreach (vecs[i]) begin
            while (e < vecs[i].edge_no) tick();
            check($sformatf("vec%0d_out", i),   32'(out_a),   32'(vecs[i].out));
            check($sformatf("vec%0d_ready", i), 32'(rdy_a),   32'(vecs[i].rdy));
            check($sformatf("vec%0d_cause", i), 32'(cause_a), 32'(vecs[i].cause));
            rst_req = vecs[i].req;
        end

        // Reset lands while u_a is in RELEASE with rst_out=100.
        check("pre_reset_out", 32'(out_a), 32'h4);
        reset = 1'b1;
        tick();
        check("midreset_out",   32'(out_a),   32'h7);
        check("midreset_ready", 32'(rdy_a),   32'h0);
        check("midreset_cause", 32'(cause_a), 32'h0);
        check("midreset_out_b", 32'(out_b),   32'h1);
        check("midreset_out_c", 32'(out_c),   32'hf);
        reset   = 1'b0;
        rst_req = 2'b00;
        e       = 0;

        for (int n = 1; n <= 42; n++) begin
            tick();
            k = released(e, 2, 16, 4, 3);
            check("seq_a_out",   32'(out_a),   out_for(k, 3));
            check("seq_a_ready", 32'(rdy_a),   32'(k == 3));
            check("seq_a_cause", 32'(cause_a), 32'h0);
            k = released(e, 3, 1, 1, 1);
            check("seq_b_out",   32'(out_b),   out_for(k, 1));
            check("seq_b_ready", 32'(rdy_b),   32'(k == 1));
            check("seq_b_cause", 32'(cause_b), 32'h0);
            k = released(e, 2, 16, 7, 4);
            check("seq_c_out",   32'(out_c),   out_for(k, 4));
            check("seq_c_ready", 32'(rdy_c),   32'(k == 4));
            check("seq_c_cause", 32'(cause_c), 32'h0);
        end

        // Anchor points of the formula stated as plain constants.
        check("b_done_e42",  32'({out_b, rdy_b}), 32'h1);
        check("c_done_e42",  32'({out_c, rdy_c}), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
